// File: rtl/sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank_writer
// Purpose  : Setup/pulse/hold write sequencer for a bank of gated SR latches,
//            with read-back verification of the masked bits.
// Revision : 1.0  initial release
// ============================================================================
module sr_bank_writer #(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_wr_mask,
    output logic [WIDTH-1:0] o_lat_set,
    output logic [WIDTH-1:0] o_lat_reset,
    output logic             o_lat_gate,
    input  logic [WIDTH-1:0] i_lat_q,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_done,
    output logic             o_err
);

    localparam int c_max_n = (SETUP_CYCLES > PULSE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int c_cw    = (c_max_n > 1) ? $clog2(c_max_n) : 1;

    localparam logic [c_cw-1:0] c_setup_ld = c_cw'(SETUP_CYCLES - 1);
    localparam logic [c_cw-1:0] c_pulse_ld = c_cw'(PULSE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_hold_ld  = c_cw'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_CHECK = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_cw-1:0]   r_cnt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]  r_dreg;
    logic [WIDTH-1:0]  r_mreg;
    logic [WIDTH-1:0]  w_dreg_nxt;
    logic [WIDTH-1:0]  w_mreg_nxt;
    logic              w_accept;
    logic              w_drive_nxt;
    logic              w_leave_hold;

    assign o_wr_ready   = (r_state == S_IDLE);
    assign w_accept     = i_wr_valid & o_wr_ready;
    assign w_leave_hold = (r_state == S_HOLD) && (r_cnt == '0);
    assign w_dreg_nxt   = w_accept ? i_wr_data : r_dreg;
    assign w_mreg_nxt   = w_accept ? i_wr_mask : r_mreg;

    // One down-counter, reloaded with N-1 whenever a timed state is entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_setup_ld;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = c_pulse_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_hold_ld;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_drive_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                         (w_state_nxt == S_HOLD);

    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // All bank drives come straight from flops keyed on the next state, so the
    // gate is glitch-free and set/reset cannot overlap (d & m vs ~d & m).
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_dreg      <= '0;
            r_mreg      <= '0;
            o_lat_set   <= '0;
            o_lat_reset <= '0;
            o_lat_gate  <= 1'b0;
            o_rd_data   <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            r_dreg      <= w_dreg_nxt;
            r_mreg      <= w_mreg_nxt;
            o_lat_set   <= w_drive_nxt ? (w_dreg_nxt & w_mreg_nxt) : '0;
            o_lat_reset <= w_drive_nxt ? (~w_dreg_nxt & w_mreg_nxt) : '0;
            o_lat_gate  <= (w_state_nxt == S_PULSE);
            o_done      <= (w_state_nxt == S_CHECK);
            if (w_accept) begin
                o_err <= 1'b0;
            end else if (w_leave_hold) begin
                o_rd_data <= i_lat_q;
                o_err     <= |((i_lat_q ^ r_dreg) & r_mreg);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_bank_writer
// Purpose  : Scoreboard bench for sr_bank_writer with a behavioural latch bank.
// Revision : 1.0  initial release
// ============================================================================
module tb_sr_bank_writer;

    localparam int c_s = 1;
    localparam int c_p = 2;
    localparam int c_h = 1;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       a_valid = 1'b0, a_ready, a_gate, a_done, a_err;
    logic [7:0] a_data = '0, a_mask = '0, a_set, a_reset, a_q, a_rd;
    logic [7:0] bank = '0, stuck0 = '0;
    logic       b_valid = 1'b0, b_ready, b_gate, b_done, b_err;
    logic [3:0] b_data = '0, b_mask = '0, b_set, b_reset, b_rd;
    logic [3:0] b_q = 4'h5;

    int         n_pass = 0, n_total = 0, cyc = 0, run = 0;
    logic [7:0] prev_set = '0, prev_reset = '0;
    exp_t       sb[$];
    exp_t       e_mon;

    always #5 clk = ~clk;

    sr_bank_writer #(.WIDTH(8), .SETUP_CYCLES(c_s), .PULSE_CYCLES(c_p), .HOLD_CYCLES(c_h)) u_a (
        .i_clock(clk), .i_clear(clear), .i_wr_valid(a_valid), .o_wr_ready(a_ready),
        .i_wr_data(a_data), .i_wr_mask(a_mask), .o_lat_set(a_set), .o_lat_reset(a_reset),
        .o_lat_gate(a_gate), .i_lat_q(a_q), .o_rd_data(a_rd), .o_done(a_done), .o_err(a_err));

    sr_bank_writer #(.WIDTH(4), .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2)) u_b (
        .i_clock(clk), .i_clear(clear), .i_wr_valid(b_valid), .o_wr_ready(b_ready),
        .i_wr_data(b_data), .i_wr_mask(b_mask), .o_lat_set(b_set), .o_lat_reset(b_reset),
        .o_lat_gate(b_gate), .i_lat_q(b_q), .o_rd_data(b_rd), .o_done(b_done), .o_err(b_err));

    // Behavioural gated SR bank with an optional stuck-at-0 overlay.
    always @(posedge clk) if (a_gate) bank <= (bank & ~a_reset) | a_set;
    assign a_q = bank & ~stuck0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: invariants every cycle and scoreboard pop on each done.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clear) begin
            chk("set_and_reset_overlap", {24'd0, a_set & a_reset}, 32'd0);
            if (a_gate) begin
                chk("set_change_under_gate", {24'd0, a_set}, {24'd0, prev_set});
                chk("reset_change_under_gate", {24'd0, a_reset}, {24'd0, prev_reset});
                run++;
            end else if (run > 0) begin
                chk("gate_width", run, c_p);
                run = 0;
            end
            if (a_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("rd_data", {24'd0, a_rd}, {24'd0, e_mon.rd});
                    chk("err", {31'd0, a_err}, {31'd0, e_mon.err});
                    chk("done_cycle", cyc, e_mon.cyc);
                end
            end
        end else begin
            run = 0;
        end
        prev_set   = a_set;
        prev_reset = a_reset;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] d, input logic [7:0] m, input logic [7:0] exp_rd,
                            input logic exp_err, input bit err_was_set);
        wait_ready();
        if (err_was_set) chk("err_held_until_accept", {31'd0, a_err}, 32'd1);
        a_valid = 1'b1;
        a_data  = d;
        a_mask  = m;
        sb.push_back('{exp_rd, exp_err, cyc + c_s + c_p + c_h + 1});
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 8'hxx;
        chk("set_after_accept", {24'd0, a_set}, {24'd0, d & m});
        chk("reset_after_accept", {24'd0, a_reset}, {24'd0, ~d & m});
        chk("gate_low_in_setup", {31'd0, a_gate}, 32'd0);
        if (err_was_set) chk("err_cleared_on_accept", {31'd0, a_err}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] w_d[3];
        logic [7:0] w_m[3];
        logic [7:0] w_r[3];
        int         acc[3];
        int         n;
        int         g_first, g_cnt, d_t;

        // Reset state
        #2 clear = 1'b0;
        #1;
        chk("rst_gate", {31'd0, a_gate}, 32'd0);
        chk("rst_set", {24'd0, a_set}, 32'd0);
        chk("rst_reset", {24'd0, a_reset}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_rd_data", {24'd0, a_rd}, 32'd0);
        #19 clear = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, a_ready}, 32'd1);

        // Basic, preload, masked write
        do_write(8'hA5, 8'hFF, 8'hA5, 1'b0, 1'b0);
        do_write(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        do_write(8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0);
        drain();

        // Stuck-at-0 on bit 3, then a mask-0 write that must clear err
        stuck0 = 8'h08;
        do_write(8'h08, 8'h08, 8'hF0, 1'b1, 1'b0);
        drain();
        do_write(8'h00, 8'h00, 8'hF0, 1'b0, 1'b1);
        drain();
        stuck0 = 8'h00;

        // Back-to-back with wr_valid held high
        w_d = '{8'h3C, 8'h00, 8'hFF};
        w_m = '{8'hFF, 8'hF0, 8'h01};
        w_r = '{8'h3C, 8'h0C, 8'h0D};
        @(negedge clk);
        a_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!a_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!a_ready) chk("b2b_ready_timeout", 32'd0, 32'd1);
            a_data = w_d[k];
            a_mask = w_m[k];
            acc[k] = cyc;
            sb.push_back('{w_r[k], 1'b0, cyc + c_s + c_p + c_h + 1});
            @(negedge clk);
        end
        a_valid = 1'b0;
        chk("b2b_spacing_1", acc[1] - acc[0], c_s + c_p + c_h + 2);
        chk("b2b_spacing_2", acc[2] - acc[1], c_s + c_p + c_h + 2);
        drain();

        // Reset while the gate is high
        wait_ready();
        a_valid = 1'b1;
        a_data  = 8'h3C;
        a_mask  = 8'hFF;
        @(negedge clk);
        a_valid = 1'b0;
        n = 0;
        while (!a_gate && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_gate_reached", {31'd0, a_gate}, 32'd1);
        #2 clear = 1'b0;
        #1;
        chk("abort_gate", {31'd0, a_gate}, 32'd0);
        chk("abort_set", {24'd0, a_set}, 32'd0);
        chk("abort_reset", {24'd0, a_reset}, 32'd0);
        chk("abort_done", {31'd0, a_done}, 32'd0);
        chk("abort_err", {31'd0, a_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, a_ready}, 32'd1);
        repeat (10) @(negedge clk);
        chk("abort_no_pending", sb.size(), 32'd0);

        // Parameter sweep instance: SETUP=3, PULSE=1, HOLD=2
        g_first = 0;
        g_cnt   = 0;
        d_t     = 0;
        chk("sweep_ready", {31'd0, b_ready}, 32'd1);
        b_valid = 1'b1;
        b_data  = 4'h5;
        b_mask  = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            b_valid = 1'b0;
            chk("sweep_set_reset_overlap", {28'd0, b_set & b_reset}, 32'd0);
            if (b_gate) begin
                if (g_first == 0) g_first = t;
                g_cnt++;
            end
            if (b_done && d_t == 0) d_t = t;
        end
        chk("sweep_gate_start", g_first, 32'd4);
        chk("sweep_gate_width", g_cnt, 32'd1);
        chk("sweep_done_time", d_t, 32'd7);
        chk("sweep_rd_data", {28'd0, b_rd}, 32'd5);
        chk("sweep_err", {31'd0, b_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sr_bank_writer.md
# sr_bank_writer

Write sequencer for a bank of WIDTH gated SR latches with an active-low clear. It accepts masked write words over a valid/ready handshake. For each word it drives the latch set, reset and gate lines through a setup, pulse and hold sequence, then reads the latch outputs back and flags any mismatch. It sits between register-file or control logic and the latch bank, and it guarantees the forbidden set=reset=1 input is never driven.

## Interface
- WIDTH, 8, number of latches in the bank (≥1)
- SETUP_CYCLES, 1, cycles set/reset are stable before the gate rises (≥1)
- PULSE_CYCLES, 2, cycles the gate is high (≥1)
- HOLD_CYCLES, 1, cycles set/reset stay stable after the gate falls (≥1)

- clock  in  1  single clock; all state updates on the rising edge
- clear  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  block can accept a write (high only in IDLE)
- wr_data  in  WIDTH  value to store
- wr_mask  in  WIDTH  1 = write this bit; 0 = leave latch untouched
- lat_set  out  WIDTH  per-bit set drive to the bank
- lat_reset  out  WIDTH  per-bit reset drive to the bank
- lat_gate  out  1  shared gate/enable to the bank
- lat_q  in  WIDTH  latch q outputs (read-back)
- rd_data  out  WIDTH  sampled lat_q from the last write
- done  out  1  one-cycle pulse: write sequence finished
- err  out  1  read-back mismatch on a masked bit of the last write

## Operation
- Reset (clear=0), asynchronous:
  - state=IDLE, counter=0.
  - lat_set=lat_reset=0, lat_gate=0, done=0, err=0, rd_data=0.
  - Captured data and mask registers are cleared to 0.
  - wr_ready=1 once clear is released (decoded from IDLE).
- Accept: wr_valid&&wr_ready at a rising edge.
  - Capture wr_data→dreg and wr_mask→mreg.
  - Clear err.
  - Go to SETUP.
  - wr_valid while not ready is ignored; no queueing.
- Per-bit drive, from registered outputs:
  - lat_set[i] = dreg[i]&mreg[i]
  - lat_reset[i] = ~dreg[i]&mreg[i]
  - Both are 0 in IDLE and whenever mreg[i]=0.
  - lat_set[i]&lat_reset[i] must never be 1 in any cycle.
- States:
  - IDLE: drives 0, wr_ready=1 → SETUP on accept.
  - SETUP: set/reset driven, gate=0, for SETUP_CYCLES → PULSE.
  - PULSE: set/reset driven, gate=1, for PULSE_CYCLES → HOLD.
  - HOLD: set/reset driven, gate=0, for HOLD_CYCLES → CHECK.
    - On the edge leaving HOLD: rd_data<=lat_q and err<=|((lat_q^dreg)&mreg).
  - CHECK: set/reset=0, gate=0, done=1 for exactly one cycle → IDLE.
- A single down-counter, loaded with (N-1) on state entry, times each of SETUP, PULSE and HOLD.
- rd_data and err hold their values until the next capture or accept.
- wr_mask=0: the full sequence still runs and the gate still pulses, but no set/reset is asserted. The bank holds its state, rd_data reflects the current lat_q, and err=0.
- lat_gate must be glitch-free: driven directly from a flop, never decoded combinationally.

## Timing
- Accept at edge E0. SETUP runs for SETUP_CYCLES, PULSE for PULSE_CYCLES, HOLD for HOLD_CYCLES, then CHECK for 1 cycle.
- Defaults (1, 2, 1):
  - SETUP during E0–E1.
  - Gate high E1–E3.
  - HOLD E3–E4.
  - done high E4–E5.
  - wr_ready high from E5.
  - Next accept is possible at E6.
- Latency from accept to done: SETUP+PULSE+HOLD cycles.
- Throughput: one write per SETUP+PULSE+HOLD+2 cycles.
- set/reset are stable SETUP_CYCLES before gate rises and HOLD_CYCLES after gate falls; they never change while gate=1.
- Reset mid-operation: gate and set/reset drop asynchronously in the same instant clear falls. No done is issued. Latch contents are undefined for the aborted word. After release the block is in IDLE with wr_ready=1.
- wr_valid and wr_data may change freely outside an accept edge; they are not sampled after capture.

## Test plan
- Reset: hold clear=0 mid-PULSE → lat_gate, lat_set, lat_reset, done and err go to 0 immediately; after release wr_ready=1, and no done is seen for the aborted write.
- Basic write, model latches behind outputs:
  - Write data=0xA5, mask=0xFF → lat_set=0xA5 and lat_reset=0x5A from E0+1.
  - gate high for exactly 2 cycles; done at E4; rd_data=0xA5, err=0.
- Masked write: preload 0xFF, then write data=0x00, mask=0x0F → lat_reset=0x0F, lat_set=0x00; rd_data=0xF0, err=0.
- Stuck-at fault: force lat_q[3]=0, write data=0x08, mask=0x08 → err=1 with done; the next accepted write clears err at its accept edge.
- Back-to-back traffic: hold wr_valid=1 for 3 words → accepts at E0, E6 and E12. Assert continuously that set&reset==0, and that set/reset never change while gate=1.
- Parameter sweep: SETUP=3, PULSE=1, HOLD=2 → gate high for 1 cycle starting 3 cycles after accept, done 6 cycles after accept.
